shared_mem_arbiter: RTL and testbench
=====================================

Name: shared_mem_arbiter

Overview:
- Shares one memory port between the pipeline's instruction-fetch stage and its data-memory stage. This lets one unified memory back both Instruction_Memory and Data_Memory traffic.
- Accepts level-held requests from both stages and arbitrates: data has priority, with a bounded starvation guard for fetch.
- Sequences a req/ack transaction on the memory port, returns read data, and drives a pipeline stall while any request is outstanding.

Parameters:
- ADDR_W, 32, address width for both requesters and the memory port
- DATA_W, 32, data width
- STARVE_MAX, 4, maximum consecutive data grants issued while a fetch is waiting; range 1..15

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- if_req_i  in  1  fetch request, level, held until if_ack_o
- if_addr_i  in  ADDR_W  fetch address
- if_ack_o  out  1  one-cycle fetch completion pulse
- if_rdata_o  out  DATA_W  fetched word
- d_req_i  in  1  data request, level, held until d_ack_o
- d_we_i  in  1  1 = write, 0 = read
- d_addr_i  in  ADDR_W  data address
- d_wdata_i  in  DATA_W  write data
- d_ack_o  out  1  one-cycle data completion pulse
- d_rdata_o  out  DATA_W  load data
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_ack_i  in  1  memory completion, one-cycle pulse; read data valid in the same cycle
- mem_rdata_i  in  DATA_W  memory read data
- stall_o  out  1  pipeline stall

Behaviour:
- Reset (rst_i=0, asynchronous):
  - State IDLE, starvation counter 0.
  - All registered outputs 0: mem_*_o, if_ack_o, d_ack_o, if_rdata_o, d_rdata_o.
  - Reset aborts any in-flight transaction; an ack arriving after reset deasserts is ignored.
- FSM states: IDLE, GNT_I, GNT_D, RESP.
- IDLE:
  - Arbitrate on sampled requests. With no request, stay in IDLE.
  - d_req_i only: go to GNT_D.
  - if_req_i only: go to GNT_I.
  - Both requests and counter < STARVE_MAX: go to GNT_D and increment the counter.
  - Both requests and counter == STARVE_MAX: go to GNT_I.
  - Counter clears on any I grant, and on a D grant made with if_req_i=0.
  - On entering GNT_x, register mem_req_o=1 and mem_addr_o/mem_we_o/mem_wdata_o from requester x. For fetch, mem_we_o=0 and mem_wdata_o=0.
- GNT_x:
  - mem_req_o and all mem_* fields are held stable until mem_ack_i=1. Wait states are unbounded.
  - On mem_ack_i=1:
    - Drop mem_req_o, pulse x_ack_o=1 next cycle, and go to RESP.
    - For a fetch or a data read, x_rdata_o latches mem_rdata_i.
    - For a data write, d_rdata_o is unchanged.
- RESP:
  - Lasts one cycle; x_ack_o is high during it. No arbitration occurs in RESP, so the still-asserted req of the acked requester is not re-granted.
  - Next state is IDLE.
  - Requesters drop or replace their req in the cycle after the ack.
- Latency: req seen at cycle t, mem_req_o high at t+1; with mem_ack_i at t+1+w, x_ack_o is high at t+2+w. Minimum 2 cycles with zero wait states.
- mem_ack_i in IDLE or RESP is ignored: no state change, no data latch.
- rdata outputs hold their last value until the next completed read of the same port.
- Request fields are sampled only at grant time; changes while granted are ignored.
- stall_o (combinational) = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o); it is 0 under reset if both reqs are 0.
- Only one memory transaction is outstanding at any time.

Test Plan:
- Fetch only, addr 0x10, mem_ack_i immediately, rdata 0xDEADBEEF -> mem_req_o high at t+1, if_ack_o one pulse at t+2, if_rdata_o=0xDEADBEEF, d_ack_o stays 0.
- Data write addr 0x40, wdata 0x1234, 3 memory wait states -> mem_we_o=1 with addr/wdata stable for 4 cycles, d_ack_o pulses at t+5, d_rdata_o unchanged.
- Both requests in the same cycle, counter 0 -> data granted first; fetch granted in the IDLE after RESP; if_ack_o follows d_ack_o by >= 3 cycles; stall_o stays high throughout.
- Both requests held continuously, STARVE_MAX=4, zero wait -> grant order D,D,D,D,I,D..., counter returns to 0 after the I grant.
- Reset pulse while in GNT_D with mem_req_o=1 -> all outputs 0 asynchronously; a subsequent stale mem_ack_i in IDLE produces no ack_o and no rdata change.
- Spurious mem_ack_i with rdata 0xFFFF_FFFF while IDLE -> state, if_rdata_o and d_rdata_o unchanged; no ack pulses.

Source files
------------

// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter: shares one memory port between fetch and data requesters, data first with bounded fetch starvation
module shared_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic              mem_ack_i,
  input  logic [DATA_W-1:0] mem_rdata_i,
  output logic              stall_o
);
  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D, RESP} state_t;
  state_t state;
  logic [3:0] cnt;
  logic pick_d;
  assign pick_d = d_req_i && !(if_req_i && cnt >= 4'(STARVE_MAX));
  assign stall_o = (if_req_i & ~if_ack_o) | (d_req_i & ~d_ack_o);
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      if_ack_o    <= 1'b0;
      d_ack_o     <= 1'b0;
      if_rdata_o  <= '0;
      d_rdata_o   <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      if_ack_o <= 1'b0;
      d_ack_o  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_d) begin
            state       <= GNT_D;
            cnt         <= if_req_i ? cnt + 4'd1 : '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= d_we_i;
            mem_addr_o  <= d_addr_i;
            mem_wdata_o <= d_wdata_i;
          end else if (if_req_i) begin
            state       <= GNT_I;
            cnt         <= '0;
            mem_req_o   <= 1'b1;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= if_addr_i;
            mem_wdata_o <= '0;
          end
        end
        GNT_I, GNT_D: begin
          if (mem_ack_i) begin
            state       <= RESP;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if (state == GNT_I) begin
              if_ack_o   <= 1'b1;
              if_rdata_o <= mem_rdata_i;
            end else begin
              d_ack_o   <= 1'b1;
              d_rdata_o <= mem_we_o ? d_rdata_o : mem_rdata_i;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_shared_mem_arbiter.sv
// tb_shared_mem_arbiter: directed and randomized checks of shared_mem_arbiter against a transaction-level model
module tb_shared_mem_arbiter;
  localparam int SM = 4;
  logic clk_i = 1'b0;
  logic rst_i = 1'b0;
  logic if_req_i = 1'b0, d_req_i = 1'b0, d_we_i = 1'b0, mem_ack_i = 1'b0;
  logic [31:0] if_addr_i = '0, d_addr_i = '0, d_wdata_i = '0, mem_rdata_i = '0;
  logic if_ack_o, d_ack_o, mem_req_o, mem_we_o, stall_o;
  logic [31:0] if_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
  int checks = 0, errors = 0;
  bit chk_en = 1'b0;
  shared_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(SM)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_ack_o(if_ack_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_ack_o(d_ack_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i), .stall_o(stall_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask
  typedef struct packed {logic v; logic d; logic we; logic [31:0] a; logic [31:0] w;} txn_t;
  txn_t cur = '0;
  int resp = 0;
  int starve = 0;
  logic [31:0] m_if_rd = '0, m_d_rd = '0;
  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cur <= '0;
      resp <= 0;
      starve <= 0;
      m_if_rd <= '0;
      m_d_rd <= '0;
    end else if (cur.v) begin
      if (mem_ack_i) begin
        resp <= cur.d ? 2 : 1;
        cur.v <= 1'b0;
        if (!cur.d) m_if_rd <= mem_rdata_i;
        else if (!cur.we) m_d_rd <= mem_rdata_i;
      end
    end else if (resp != 0) begin
      resp <= 0;
    end else if (d_req_i && !(if_req_i && starve >= SM)) begin
      cur <= '{1'b1, 1'b1, d_we_i, d_addr_i, d_wdata_i};
      starve <= if_req_i ? starve + 1 : 0;
    end else if (if_req_i) begin
      cur <= '{1'b1, 1'b0, 1'b0, if_addr_i, 32'h0};
      starve <= 0;
    end
  end
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("mem_req", {31'b0, mem_req_o}, {31'b0, cur.v});
      chk("mem_we", {31'b0, mem_we_o}, {31'b0, cur.v & cur.we});
      chk("mem_addr", mem_addr_o, cur.v ? cur.a : 32'h0);
      chk("mem_wdata", mem_wdata_o, cur.v ? cur.w : 32'h0);
      chk("if_ack", {31'b0, if_ack_o}, {31'b0, resp == 1});
      chk("d_ack", {31'b0, d_ack_o}, {31'b0, resp == 2});
      chk("if_rdata", if_rdata_o, m_if_rd);
      chk("d_rdata", d_rdata_o, m_d_rd);
      chk("stall", {31'b0, stall_o}, {31'b0, (if_req_i && resp != 1) || (d_req_i && resp != 2)});
    end
  end
  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask
  logic [9:0] order;
  int ng;
  bit stop, i_prev, d_prev;
  initial begin
    cyc();
    chk("rst_mem_req", {31'b0, mem_req_o}, 32'h0);
    chk("rst_stall", {31'b0, stall_o}, 32'h0);
    rst_i = 1'b1;
    chk_en = 1'b1;
    cyc();
    if_req_i = 1'b1;
    if_addr_i = 32'h10;
    cyc();
    chk("t1_mem_req", {31'b0, mem_req_o}, 32'h1);
    chk("t1_mem_addr", mem_addr_o, 32'h10);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hDEADBEEF;
    cyc();
    mem_ack_i = 1'b0;
    chk("t1_if_ack", {31'b0, if_ack_o}, 32'h1);
    chk("t1_if_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("t1_d_ack", {31'b0, d_ack_o}, 32'h0);
    cyc();
    if_req_i = 1'b0;
    chk("t1_if_ack_pulse", {31'b0, if_ack_o}, 32'h0);
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    cyc();
    mem_ack_i = 1'b0;
    chk("spur_if_rdata", if_rdata_o, 32'hDEADBEEF);
    chk("spur_d_rdata", d_rdata_o, 32'h0);
    chk("spur_acks", {30'b0, if_ack_o, d_ack_o}, 32'h0);
    chk("spur_mem_req", {31'b0, mem_req_o}, 32'h0);
    d_req_i = 1'b1;
    d_we_i = 1'b1;
    d_addr_i = 32'h40;
    d_wdata_i = 32'h1234;
    for (int i = 1; i <= 4; i++) begin
      cyc();
      chk("t2_mem_we", {31'b0, mem_we_o}, 32'h1);
      chk("t2_mem_addr", mem_addr_o, 32'h40);
      chk("t2_mem_wdata", mem_wdata_o, 32'h1234);
      chk("t2_d_ack_wait", {31'b0, d_ack_o}, 32'h0);
      mem_ack_i = (i == 4);
      mem_rdata_i = 32'h0BAD0BAD;
    end
    cyc();
    mem_ack_i = 1'b0;
    chk("t2_d_ack", {31'b0, d_ack_o}, 32'h1);
    chk("t2_d_rdata", d_rdata_o, 32'h0);
    cyc();
    d_req_i = 1'b0;
    d_we_i = 1'b0;
    if_req_i = 1'b1;
    if_addr_i = 32'h100;
    d_req_i = 1'b1;
    d_addr_i = 32'h200;
    ng = 0;
    stop = 1'b0;
    order = '0;
    for (int i = 0; i < 45; i++) begin
      cyc();
      if (stop) begin
        if_req_i = 1'b0;
        d_req_i = 1'b0;
        mem_ack_i = 1'b0;
        break;
      end
      chk("t3_stall", {31'b0, stall_o}, 32'h1);
      if (mem_req_o) begin
        if (ng < 10) order[ng] = (mem_addr_o == 32'h100);
        ng++;
      end
      mem_ack_i = mem_req_o;
      mem_rdata_i = 32'hC0DE0000 + 32'(i);
      stop = (ng >= 10) && (if_ack_o || d_ack_o);
    end
    chk("t3_grants", 32'(ng), 32'd10);
    chk("t3_order", {22'b0, order}, {22'b0, 10'b1000010000});
    d_req_i = 1'b1;
    d_addr_i = 32'h80;
    cyc();
    cyc();
    chk("t5_mem_req", {31'b0, mem_req_o}, 32'h1);
    #2;
    rst_i = 1'b0;
    d_req_i = 1'b0;
    #1;
    chk("t5_rst_mem", {mem_req_o, mem_we_o, mem_addr_o[29:0]} | mem_wdata_o, 32'h0);
    chk("t5_rst_acks", {30'b0, if_ack_o, d_ack_o}, 32'h0);
    chk("t5_rst_if_rdata", if_rdata_o, 32'h0);
    chk("t5_rst_d_rdata", d_rdata_o, 32'h0);
    chk("t5_rst_stall", {31'b0, stall_o}, 32'h0);
    @(negedge clk_i);
    #1;
    rst_i = 1'b1;
    cyc();
    mem_ack_i = 1'b1;
    mem_rdata_i = 32'hFFFFFFFF;
    cyc();
    mem_ack_i = 1'b0;
    chk("t5_stale_acks", {30'b0, if_ack_o, d_ack_o}, 32'h0);
    chk("t5_stale_rdata", if_rdata_o | d_rdata_o, 32'h0);
    i_prev = 1'b0;
    d_prev = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (!rst_i) rst_i = 1'b1;
      if (i_prev) if_req_i = ($urandom % 2) == 0;
      else if (!if_req_i) if_req_i = ($urandom % 3) == 0;
      if (d_prev) d_req_i = ($urandom % 2) == 0;
      else if (!d_req_i) d_req_i = ($urandom % 3) == 0;
      if_addr_i = $urandom;
      d_addr_i = $urandom;
      d_wdata_i = $urandom;
      d_we_i = $urandom % 2;
      mem_ack_i = mem_req_o ? ($urandom % 3) == 0 : ($urandom % 8) == 0;
      mem_rdata_i = $urandom;
      i_prev = if_ack_o;
      d_prev = d_ack_o;
      if (i % 1000 == 500) begin
        #2;
        rst_i = 1'b0;
        i_prev = 1'b0;
        d_prev = 1'b0;
      end
    end
    cyc();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
